// File: rtl/matmul_calc_pkg.sv
// rtl/matmul_calc_pkg.sv - shared constants, register map and FSM types for matmul_ctrl
package matmul_calc_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = 4;
  localparam int DIM_W      = $clog2(MAX_DIM);
  localparam int CNT_W      = $clog2(3 * MAX_DIM);

  localparam logic [4:0] OFF_CONTROL = 5'h00;
  localparam logic [4:0] OFF_STATUS  = 5'h04;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_N_LSB     = 2;
  localparam int CTRL_K_LSB     = 4;
  localparam int CTRL_M_LSB     = 6;
  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_BUSY_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_WB
  } ctrl_state_t;

  // Each dimension is stored as dim-1, so all-zero means a 1x1x1 product.
  typedef struct packed {
    logic [DIM_W-1:0] m_m1;
    logic [DIM_W-1:0] k_m1;
    logic [DIM_W-1:0] n_m1;
  } dims_t;

  // Last FEED count: (K+N+M-2) cycles minus one, which is the sum of the dim-1 fields.
  function automatic logic [CNT_W-1:0] feed_last(input dims_t d);
    return CNT_W'(d.n_m1) + CNT_W'(d.k_m1) + CNT_W'(d.m_m1);
  endfunction

endpackage

// File: rtl/matmul_ctrl_if.sv
// rtl/matmul_ctrl_if.sv - APB register port bundle for matmul_ctrl
interface matmul_ctrl_if;
  import matmul_calc_pkg::*;

  logic                    psel_i;
  logic                    penable_i;
  logic                    pwrite_i;
  logic [ADDR_WIDTH-1:0]   paddr_i;
  logic [BUS_WIDTH-1:0]    pwdata_i;
  logic [BUS_WIDTH/8-1:0]  pstrb_i;
  logic                    pready_o;
  logic                    pslverr_o;
  logic [BUS_WIDTH-1:0]    prdata_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  pready_o, pslverr_o, prdata_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output pready_o, pslverr_o, prdata_o
  );

endinterface

// File: rtl/matmul_ctrl_regs.sv
// rtl/matmul_ctrl_regs.sv - APB decode, CONTROL/STATUS registers and START pulse
module matmul_ctrl_regs
  import matmul_calc_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  matmul_ctrl_if.slave  apb,
  input  logic          busy_i,
  input  logic          done_set_i,
  output logic          start_o,
  output dims_t         dims_o
);

  logic [4:0]           offset;
  logic                 setup;
  logic                 access;
  logic                 is_ctrl;
  logic                 is_stat;
  logic                 err_c;
  logic                 ctrl_we;
  logic                 stat_we;
  logic [BUS_WIDTH-1:0] rd_c;
  logic                 done_q;
  dims_t                dims_q;
  logic                 unused_bits;

  assign offset  = apb.paddr_i[4:0];
  assign setup   = apb.psel_i & ~apb.penable_i;
  assign access  = apb.psel_i & apb.penable_i & apb.pready_o;
  assign is_ctrl = (offset == OFF_CONTROL);
  assign is_stat = (offset == OFF_STATUS);

  // The error is decided in the setup phase, so a CONTROL write is rejected
  // based on busy as seen when the transfer was presented.
  assign err_c = ~(is_ctrl | is_stat) | (is_ctrl & apb.pwrite_i & busy_i);

  always_comb begin
    rd_c = '0;
    if (!apb.pwrite_i) begin
      if (is_ctrl) begin
        rd_c[CTRL_N_LSB +: DIM_W] = dims_q.n_m1;
        rd_c[CTRL_K_LSB +: DIM_W] = dims_q.k_m1;
        rd_c[CTRL_M_LSB +: DIM_W] = dims_q.m_m1;
      end else if (is_stat) begin
        rd_c[STAT_DONE_BIT] = done_q;
        rd_c[STAT_BUSY_BIT] = busy_i;
      end
    end
  end

  assign ctrl_we = access & apb.pwrite_i & is_ctrl & apb.pstrb_i[0] & ~apb.pslverr_o;
  assign stat_we = access & apb.pwrite_i & is_stat & apb.pstrb_i[0];
  assign start_o = ctrl_we & apb.pwdata_i[CTRL_START_BIT];
  assign dims_o  = dims_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      apb.pready_o  <= 1'b0;
      apb.pslverr_o <= 1'b0;
      apb.prdata_o  <= '0;
      done_q        <= 1'b0;
      dims_q        <= '0;
    end else begin
      apb.pready_o  <= setup;
      apb.pslverr_o <= setup & err_c;
      apb.prdata_o  <= setup ? rd_c : '0;
      if (ctrl_we) begin
        dims_q.n_m1 <= apb.pwdata_i[CTRL_N_LSB +: DIM_W];
        dims_q.k_m1 <= apb.pwdata_i[CTRL_K_LSB +: DIM_W];
        dims_q.m_m1 <= apb.pwdata_i[CTRL_M_LSB +: DIM_W];
      end
      if (done_set_i) begin
        done_q <= 1'b1;
      end else if (start_o || (stat_we && apb.pwdata_i[STAT_DONE_BIT])) begin
        done_q <= 1'b0;
      end
    end
  end

  assign unused_bits = &{1'b0, apb.paddr_i[ADDR_WIDTH-1:5], apb.pwdata_i[BUS_WIDTH-1:8],
                         apb.pwdata_i[1], apb.pstrb_i[BUS_WIDTH/8-1:1]};

endmodule

// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - matmul sequencer: clear, systolic feed and result writeback
module matmul_ctrl
  import matmul_calc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  matmul_ctrl_if.slave      apb,
  output logic              busy_o,
  output logic              pe_clr_o,
  output logic              pe_en_o,
  output logic              op_rd_en_o,
  output logic [DIM_W-1:0]  op_k_o,
  output logic              res_wr_en_o,
  output logic [DIM_W-1:0]  res_row_o
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start;
  logic             done_set;
  dims_t            dims;

  matmul_ctrl_regs u_regs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .apb        (apb),
    .busy_i     (busy_o),
    .done_set_i (done_set),
    .start_o    (start),
    .dims_o     (dims)
  );

  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One counter is shared by FEED and WB; it restarts at zero on every state entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pe_clr_o    = 1'b0;
    pe_en_o     = 1'b0;
    op_rd_en_o  = 1'b0;
    op_k_o      = '0;
    res_wr_en_o = 1'b0;
    res_row_o   = '0;
    done_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        pe_clr_o = 1'b1;
        cnt_d    = '0;
        state_d  = ST_FEED;
      end
      ST_FEED: begin
        pe_en_o = 1'b1;
        if (cnt_q <= CNT_W'(dims.k_m1)) begin
          op_rd_en_o = 1'b1;
          op_k_o     = cnt_q[DIM_W-1:0];
        end
        if (cnt_q == feed_last(dims)) begin
          cnt_d   = '0;
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        res_wr_en_o = 1'b1;
        res_row_o   = cnt_q[DIM_W-1:0];
        if (cnt_q == CNT_W'(dims.n_m1)) begin
          cnt_d    = '0;
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - self-checking bench for matmul_ctrl against a cycle-trace model
module tb_matmul_ctrl;
  import matmul_calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, pe_clr, pe_en, op_rd_en, res_wr_en;
  logic [1:0] op_k, res_row;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  matmul_ctrl_if bus ();

  matmul_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .apb         (bus),
    .busy_o      (busy),
    .pe_clr_o    (pe_clr),
    .pe_en_o     (pe_en),
    .op_rd_en_o  (op_rd_en),
    .op_k_o      (op_k),
    .res_wr_en_o (res_wr_en),
    .res_row_o   (res_row)
  );

  function automatic logic [8:0] obs();
    return {busy, pe_clr, pe_en, op_rd_en, op_k, res_wr_en, res_row};
  endfunction

  function automatic logic [31:0] cw(input int n, input int k, input int m, input bit st);
    return 32'(((m - 1) << 6) | ((k - 1) << 4) | ((n - 1) << 2) | int'(st));
  endfunction

  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic rdy, output logic err,
                          output logic [31:0] rdata);
    @(posedge clk); #1;
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = wr;
    bus.paddr_i   = addr;
    bus.pwdata_i  = data;
    bus.pstrb_i   = strb;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    @(negedge clk);
    rdy   = bus.pready_o;
    err   = bus.pslverr_o;
    rdata = bus.prdata_o;
    @(posedge clk); #1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
  endtask

  // Expected per-cycle strobes from the dimensions: 1 clear, K+N+M-2 feed steps
  // (operands only on the first K), then N writeback rows.
  task automatic check_run(input int n, input int k, input int m, input bit idle_after,
                           input string name, output int nbusy);
    int         f;
    int         total;
    logic       e_clr, e_en, e_rd, e_wr;
    int         e_k, e_row;
    logic [8:0] exp;
    f     = k + n + m - 2;
    total = 1 + f + n;
    nbusy = 0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      e_clr = 0; e_en = 0; e_rd = 0; e_wr = 0; e_k = 0; e_row = 0;
      if (i == 0) e_clr = 1;
      else if (i - 1 < f) begin
        e_en = 1;
        if (i - 1 < k) begin
          e_rd = 1;
          e_k  = i - 1;
        end
      end else begin
        e_wr  = 1;
        e_row = i - 1 - f;
      end
      exp = {1'b1, e_clr, e_en, e_rd, 2'(e_k), e_wr, 2'(e_row)};
      if (busy) nbusy++;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b want %b", name, i, obs(), exp);
      end
    end
    if (idle_after) begin
      @(negedge clk);
      checks++;
      if (obs() !== 9'b0) begin
        errors++;
        $display("FAIL %s idle: got %b want %b", name, obs(), 9'b0);
      end
    end
  endtask

  task automatic test_reset();
    logic rdy, err;
    logic [31:0] rd;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({obs(), bus.pready_o, bus.pslverr_o, bus.prdata_o} !== 43'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b/%b/%h want 0", obs(), bus.pready_o, bus.pslverr_o, bus.prdata_o);
    end
    rst = 1'b0;
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if ({rdy, err, rd} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL reset_status: got rdy=%b err=%b data=%h want 1/0/0", rdy, err, rd);
    end
    apb_xfer(0, 16'h0, 0, 0, rdy, err, rd);
    checks++;
    if ({rdy, err, rd, bus.pready_o} !== {2'b10, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_control: got rdy=%b err=%b data=%h after=%b want 1/0/0/0", rdy, err, rd, bus.pready_o);
    end
  endtask

  task automatic test_run_2x2x2();
    logic rdy, err;
    logic [31:0] rd;
    int nb;
    apb_xfer(1, 16'h0, 32'h55, 4'hF, rdy, err, rd);
    checks++;
    if ({rdy, err} !== 2'b10) begin
      errors++;
      $display("FAIL start_2x2x2: got rdy=%b err=%b want 1/0", rdy, err);
    end
    check_run(2, 2, 2, 1, "run_2x2x2", nb);
    checks++;
    if (nb !== 7) begin
      errors++;
      $display("FAIL busy_len_2x2x2: got %0d want 7", nb);
    end
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL status_2x2x2: got %h want 1", rd);
    end
    apb_xfer(0, 16'h0, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h54) begin
      errors++;
      $display("FAIL control_2x2x2: got %h want 54", rd);
    end
  endtask

  task automatic test_write_while_busy();
    logic rdy, err, rdy2, err2;
    logic [31:0] rd, rd2;
    int nb;
    apb_xfer(1, 16'h0, cw(3, 3, 3, 1), 4'hF, rdy, err, rd);
    fork
      check_run(3, 3, 3, 1, "busy_run", nb);
      begin
        repeat (2) @(posedge clk);
        apb_xfer(1, 16'h0, 32'h1, 4'hF, rdy, err, rd);
        apb_xfer(0, 16'h4, 0, 0, rdy2, err2, rd2);
      end
    join
    checks++;
    if ({rdy, err} !== 2'b11) begin
      errors++;
      $display("FAIL busy_write_err: got rdy=%b err=%b want 1/1", rdy, err);
    end
    checks++;
    if ({err2, rd2} !== {1'b0, 32'h2}) begin
      errors++;
      $display("FAIL busy_status: got err=%b data=%h want 0/2", err2, rd2);
    end
    apb_xfer(0, 16'h0, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'hA8) begin
      errors++;
      $display("FAIL busy_dims_kept: got %h want a8", rd);
    end
    apb_xfer(1, 16'h8, 32'hFFFF_FFFF, 4'hF, rdy, err, rd);
    checks++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bad_offset_write: got err=%b data=%h want 1/0", err, rd);
    end
    apb_xfer(0, 16'h1C, 0, 0, rdy, err, rd);
    checks++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bad_offset_read: got err=%b data=%h want 1/0", err, rd);
    end
  endtask

  task automatic test_strobe_and_clear();
    logic rdy, err;
    logic [31:0] rd;
    logic any;
    apb_xfer(1, 16'h0, 32'h55, 4'h0, rdy, err, rd);
    any = err;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any |= busy | pe_clr | pe_en;
    end
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL strobe0_no_start: got %b want 0", any);
    end
    apb_xfer(0, 16'h0, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'hA8) begin
      errors++;
      $display("FAIL strobe0_dims: got %h want a8", rd);
    end
    apb_xfer(1, 16'h4, 32'h1, 4'h0, rdy, err, rd);
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL strobe0_clear_ignored: got %h want 1", rd);
    end
    apb_xfer(1, 16'h4, 32'h1, 4'hF, rdy, err, rd);
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL done_clear: got %h want 0", rd);
    end
  endtask

  task automatic test_random_runs();
    logic rdy, err;
    logic [31:0] rd;
    int n, k, m, nb;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      k = $urandom_range(1, 4);
      m = $urandom_range(1, 4);
      apb_xfer(1, 16'h0, cw(n, k, m, 1), 4'hF, rdy, err, rd);
      check_run(n, k, m, 1, $sformatf("rand_%0dx%0dx%0d", n, k, m), nb);
      checks++;
      if (nb !== 1 + (k + n + m - 2) + n) begin
        errors++;
        $display("FAIL rand_latency: got %0d want %0d", nb, 1 + (k + n + m - 2) + n);
      end
      apb_xfer(0, 16'h0, 0, 0, rdy, err, rd);
      checks++;
      if (rd !== (cw(n, k, m, 0))) begin
        errors++;
        $display("FAIL rand_control: got %h want %h", rd, cw(n, k, m, 0));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic rdy, err;
    logic [31:0] rd;
    int nb;
    apb_xfer(1, 16'h0, cw(4, 4, 4, 1), 4'hF, rdy, err, rd);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, pe_en} !== 2'b11) begin
      errors++;
      $display("FAIL midrun_in_feed: got %b want 11", {busy, pe_en});
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 9'b0) begin
      errors++;
      $display("FAIL midrun_reset: got %b want 0", obs());
    end
    rst = 1'b0;
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL midrun_status: got %h want 0", rd);
    end
    apb_xfer(0, 16'h0, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL midrun_dims: got %h want 0", rd);
    end
    apb_xfer(1, 16'h0, 32'h1, 4'hF, rdy, err, rd);
    check_run(1, 1, 1, 1, "after_reset_1x1x1", nb);
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL after_reset_done: got %h want 1", rd);
    end
  endtask

  task automatic test_max_size();
    logic rdy, err;
    logic [31:0] rd;
    int nb;
    apb_xfer(1, 16'h0, 32'hFD, 4'hF, rdy, err, rd);
    check_run(4, 4, 4, 1, "max_4x4x4", nb);
    checks++;
    if (nb !== 15) begin
      errors++;
      $display("FAIL max_latency: got %0d want 15", nb);
    end
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL max_done: got %h want 1", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, err;
    logic [31:0] rd;
    int nb;
    apb_xfer(1, 16'h0, cw(2, 1, 3, 1), 4'hF, rdy, err, rd);
    check_run(2, 1, 3, 0, "b2b_first", nb);
    apb_xfer(1, 16'h0, cw(3, 2, 1, 1), 4'hF, rdy, err, rd);
    checks++;
    if ({rdy, err} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_start: got rdy=%b err=%b want 1/0", rdy, err);
    end
    check_run(3, 2, 1, 1, "b2b_second", nb);
    apb_xfer(0, 16'h4, 0, 0, rdy, err, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL b2b_done: got %h want 1", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    bus.paddr_i   = '0;
    bus.pwdata_i  = '0;
    bus.pstrb_i   = '0;
    test_reset();
    test_run_2x2x2();
    test_write_while_busy();
    test_strobe_and_clear();
    test_random_runs();
    test_reset_mid_run();
    test_max_size();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
